alu_issue_ctrl: RTL and testbench

Multi-cycle issue controller that drives the integer ALU. Accepts one RV32I register/immediate ALU instruction at a time over a valid/ready handshake. Sequences register-file read, ALU evaluation and register write-back through a small state machine. Sits between instruction fetch and the register file / ALU pair; it produces the ALU `opcode/left/right` inputs and consumes the ALU `result`.

---
 rtl/alu_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for the integer ALU: accepts one RV32I R/I-type
// ALU instruction, sequences register read, ALU evaluation and write-back.
module alu_issue_ctrl #(
  parameter int unsigned SYNC_RF = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [2:0]  alu_opcode,
  output logic [31:0] alu_left,
  output logic [31:0] alu_right,
  input  logic [31:0] alu_result,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  output logic        illegal
);

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] ALU_OP_ADD = 3'd0;
  localparam logic [2:0] ALU_OP_SUB = 3'd1;
  localparam logic [2:0] ALU_OP_AND = 3'd2;
  localparam logic [2:0] ALU_OP_OR  = 3'd3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic            imm_sel_q;
  logic [XLEN-1:0] imm_q;

  logic            dec_ok;
  logic [2:0]      dec_op;
  logic            dec_imm_sel;
  logic            exec;

  // Decode of the supported R-type and I-type ALU instructions
  always_comb begin
    dec_ok      = 1'b0;
    dec_op      = ALU_OP_ADD;
    dec_imm_sel = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        if (instr[31:25] == F7_BASE) begin
          case (instr[14:12])
            3'b000:  begin dec_ok = 1'b1; dec_op = ALU_OP_ADD; end
            3'b111:  begin dec_ok = 1'b1; dec_op = ALU_OP_AND; end
            3'b110:  begin dec_ok = 1'b1; dec_op = ALU_OP_OR;  end
            default: dec_ok = 1'b0;
          endcase
        end else if ((instr[31:25] == F7_ALT) && (instr[14:12] == 3'b000)) begin
          dec_ok = 1'b1;
          dec_op = ALU_OP_SUB;
        end
      end
      OPC_OPIMM: begin
        dec_imm_sel = 1'b1;
        case (instr[14:12])
          3'b000:  begin dec_ok = 1'b1; dec_op = ALU_OP_ADD; end
          3'b111:  begin dec_ok = 1'b1; dec_op = ALU_OP_AND; end
          3'b110:  begin dec_ok = 1'b1; dec_op = ALU_OP_OR;  end
          default: dec_ok = 1'b0;
        endcase
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Sequencer with registered addresses, write-back and fault pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      rs1_addr  <= 5'd0;
      rs2_addr  <= 5'd0;
      rd_addr   <= 5'd0;
      rd_wdata  <= '0;
      rd_we     <= 1'b0;
      illegal   <= 1'b0;
      op_q      <= ALU_OP_ADD;
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
    end else begin
      rd_we   <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            rs1_addr  <= instr[19:15];
            rs2_addr  <= instr[24:20];
            rd_addr   <= instr[11:7];
            op_q      <= dec_op;
            imm_sel_q <= dec_imm_sel;
            imm_q     <= {{(XLEN-12){instr[31]}}, instr[31:20]};
            if (!dec_ok) begin
              state   <= S_FAULT;
              illegal <= 1'b1;
            end else if (SYNC_RF != 0) begin
              state <= S_READ;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_READ: state <= S_EXEC;
        S_EXEC: begin
          rd_wdata <= alu_result;
          rd_we    <= (rd_addr != 5'd0);
          state    <= S_WB;
        end
        S_WB:    state <= S_IDLE;
        S_FAULT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operands must follow register-file data within the EXEC cycle, so they are gated, not registered
  assign exec        = (state == S_EXEC);
  assign instr_ready = (state == S_IDLE) && reset_n;
  assign alu_opcode  = exec ? op_q : 3'b000;
  assign alu_left    = exec ? rs1_data : '0;
  assign alu_right   = exec ? (imm_sel_q ? imm_q : rs2_data) : '0;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl (SYNC_RF=1): table of instructions with
// a register-file and ALU model around the DUT and a write-back scoreboard.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_left, alu_right;
  logic [31:0] alu_result;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.SYNC_RF(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .alu_opcode (alu_opcode),
    .alu_left   (alu_left),
    .alu_right  (alu_right),
    .alu_result (alu_result),
    .rd_we      (rd_we),
    .rd_addr    (rd_addr),
    .rd_wdata   (rd_wdata),
    .illegal    (illegal)
  );

  // Registered-read register file; ld preloads x1/x2 on the next edge
  logic [31:0] rf [32];
  logic        ld;
  logic [31:0] ld_a, ld_b;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      if (rd_we && rd_addr != 5'd0) rf[rd_addr] <= rd_wdata;
      if (ld) begin
        rf[1] <= ld_a;
        rf[2] <= ld_b;
      end
    end
    rs1_data <= (rs1_addr == 5'd0) ? 32'd0 : rf[rs1_addr];
    rs2_data <= (rs2_addr == 5'd0) ? 32'd0 : rf[rs2_addr];
  end

  // ALU model: 0 add, 1 sub, 2 and, 3 or
  always_comb begin
    case (alu_opcode)
      3'd0:    alu_result = alu_left + alu_right;
      3'd1:    alu_result = alu_left - alu_right;
      3'd2:    alu_result = alu_left & alu_right;
      3'd3:    alu_result = alu_left | alu_right;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t sb [$];

  // Write-back monitor: every rd_we pulse must match the oldest expected write
  always @(negedge clk) begin
    wb_t e;
    if (reset_n && rd_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(rd_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("wb_rd_addr", 32'(rd_addr), 32'(e.rd));
        chk("wb_rd_wdata", rd_wdata, e.data);
      end
    end
  end

  typedef struct {
    logic [31:0] instr;
    logic        load;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] right;
    logic        ill;
    logic        we;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [14];

  task automatic run_vec(input vec_t v);
    wb_t e;
    ld          = v.load;
    ld_a        = v.a;
    ld_b        = v.b;
    instr       = v.instr;
    instr_valid = 1'b1;
    chk("ready_before_accept", 32'(instr_ready), 32'd1);
    if (v.we) begin
      e.rd   = v.instr[11:7];
      e.data = v.data;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    ld          = 1'b0;
    @(negedge clk);
    if (v.ill) begin
      chk("fault_illegal", 32'(illegal), 32'd1);
      chk("fault_no_we", 32'(rd_we), 32'd0);
      chk("fault_not_ready", 32'(instr_ready), 32'd0);
      @(negedge clk);
      chk("illegal_one_cycle", 32'(illegal), 32'd0);
      chk("ready_after_fault", 32'(instr_ready), 32'd1);
    end else begin
      chk("read_not_ready", 32'(instr_ready), 32'd0);
      chk("read_alu_left_zero", alu_left, 32'd0);
      chk("read_alu_right_zero", alu_right, 32'd0);
      chk("read_no_illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      chk("exec_alu_left", alu_left, v.a);
      chk("exec_alu_right", alu_right, v.right);
      chk("exec_not_ready", 32'(instr_ready), 32'd0);
      @(negedge clk);
      chk("wb_we", 32'(rd_we), 32'(v.we));
      chk("wb_rs1_hold", 32'(rs1_addr), 32'(v.instr[19:15]));
      chk("wb_alu_opcode_zero", 32'(alu_opcode), 32'd0);
      chk("wb_not_ready", 32'(instr_ready), 32'd0);
      @(negedge clk);
      chk("idle_ready", 32'(instr_ready), 32'd1);
      chk("we_single_pulse", 32'(rd_we), 32'd0);
    end
  endtask

  initial begin
    //           instr         load  a             b             right         ill   we    data
    vecs[0]  = '{32'h002081B3, 1'b1, 32'd5,        32'd7,        32'd7,        1'b0, 1'b1, 32'd12};
    vecs[1]  = '{32'h40208233, 1'b1, 32'd0,        32'd1,        32'd1,        1'b0, 1'b1, 32'hFFFF_FFFF};
    vecs[2]  = '{32'hFFD08293, 1'b1, 32'd10,       32'd0,        32'hFFFF_FFFD, 1'b0, 1'b1, 32'd7};
    vecs[3]  = '{32'h0020F333, 1'b1, 32'hF0F01234, 32'h0FF0FF00, 32'h0FF0FF00, 1'b0, 1'b1, 32'h00F01200};
    vecs[4]  = '{32'h0020E3B3, 1'b1, 32'hF0000001, 32'h00000F00, 32'h00000F00, 1'b0, 1'b1, 32'hF0000F01};
    vecs[5]  = '{32'h0F00F413, 1'b1, 32'h12345678, 32'd0,        32'h000000F0, 1'b0, 1'b1, 32'h00000070};
    vecs[6]  = '{32'hFFF0E493, 1'b1, 32'h00000010, 32'd0,        32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF};
    vecs[7]  = '{32'h0FF0E013, 1'b1, 32'd5,        32'd0,        32'h000000FF, 1'b0, 1'b0, 32'd0};
    vecs[8]  = '{32'h00208533, 1'b1, 32'hFFFF_FFFF, 32'd2,       32'd2,        1'b0, 1'b1, 32'd1};
    vecs[9]  = '{32'h00000073, 1'b0, 32'd0,        32'd0,        32'd0,        1'b1, 1'b0, 32'd0};
    vecs[10] = '{32'h022081B3, 1'b0, 32'd0,        32'd0,        32'd0,        1'b1, 1'b0, 32'd0};
    vecs[11] = '{32'h00108093, 1'b1, 32'd100,      32'd0,        32'd1,        1'b0, 1'b1, 32'd101};
    vecs[12] = '{32'h00108093, 1'b0, 32'd101,      32'd0,        32'd1,        1'b0, 1'b1, 32'd102};
    vecs[13] = '{32'h002081B3, 1'b1, 32'd3,        32'd4,        32'd4,        1'b0, 1'b1, 32'd7};

    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'd0;
    ld          = 1'b0;
    ld_a        = 32'd0;
    ld_b        = 32'd0;

    repeat (2) @(negedge clk);
    chk("rst_ready_low", 32'(instr_ready), 32'd0);
    chk("rst_rd_we", 32'(rd_we), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_rs1_addr", 32'(rs1_addr), 32'd0);
    chk("rst_rd_wdata", rd_wdata, 32'd0);
    chk("rst_alu_left", alu_left, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("ready_after_release", 32'(instr_ready), 32'd1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Reset asserted in the middle of EXEC drops the pending write
    ld          = 1'b1;
    ld_a        = 32'd9;
    ld_b        = 32'd9;
    instr       = 32'h002081B3;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    ld          = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_exec_left", alu_left, 32'd9);
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(instr_ready), 32'd0);
    chk("midrst_rd_we", 32'(rd_we), 32'd0);
    chk("midrst_illegal", 32'(illegal), 32'd0);
    chk("midrst_alu_left", alu_left, 32'd0);
    chk("midrst_alu_right", alu_right, 32'd0);
    chk("midrst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("midrst_rs1_addr", 32'(rs1_addr), 32'd0);
    chk("midrst_rd_addr", 32'(rd_addr), 32'd0);
    chk("midrst_rd_wdata", rd_wdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_no_write", 32'(rd_we), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("midrst_ready_after", 32'(instr_ready), 32'd1);
    run_vec(vecs[13]);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
